fetch_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline: the PC register, next-PC selection and the IF/ID pipeline register.
- Sits directly upstream of decode.
- Consumes StallF/StallD from the hazard unit, and the branch/jump redirect resolved in decode.
- Produces PCF to instruction memory and InstrD/PCPlus4D to decode.
- Contains a small run-control FSM (BOOT/RUN/HALTED).

---
 rtl/fetch_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register, run control
module fetch_stage #(
   parameter int unsigned PC_WIDTH = 32,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   StallF,
   input  logic                   StallD,
   input  logic                   PCSrcD,
   input  logic                   JumpD,
   input  logic [PC_WIDTH-1:0]    PCBranchD,
   input  logic [PC_WIDTH-1:0]    PCJumpD,
   input  logic                   HaltD,
   input  logic [INSTR_WIDTH-1:0] InstrF,
   output logic [PC_WIDTH-1:0]    PCF,
   output logic [INSTR_WIDTH-1:0] InstrD,
   output logic [PC_WIDTH-1:0]    PCPlus4D,
   output logic                   ValidD,
   output logic                   Halted
);

   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} runState_t;

   runState_t              state, stateNext;
   logic [PC_WIDTH-1:0]    pcNext, pcPlus4F, pcPlus4Next;
   logic [INSTR_WIDTH-1:0] instrNext;
   logic                   validNext;
   logic                   redirect, haltNow;

   assign pcPlus4F = PCF + PC_WIDTH'(4);
   assign redirect = JumpD | PCSrcD;
   assign haltNow  = HaltD & ValidD & ~StallD;
   assign Halted   = (state == HALTED);

   always_comb begin
      stateNext   = state;
      pcNext      = PCF;
      instrNext   = InstrD;
      pcPlus4Next = PCPlus4D;
      validNext   = ValidD;
      case (state)
         BOOT: begin
            stateNext   = RUN;
            instrNext   = NOP_INSTR;
            pcPlus4Next = '0;
            validNext   = 1'b0;
         end
         RUN: begin
            // Halt beats any redirect: the halt instruction itself sits in decode.
            if (haltNow) begin
               stateNext   = HALTED;
               instrNext   = NOP_INSTR;
               pcPlus4Next = '0;
               validNext   = 1'b0;
            end else begin
               if (!StallF) begin
                  if (JumpD)       pcNext = PCJumpD;
                  else if (PCSrcD) pcNext = PCBranchD;
                  else             pcNext = pcPlus4F;
               end
               if (!StallD) begin
                  if (redirect) begin
                     instrNext   = NOP_INSTR;
                     pcPlus4Next = '0;
                     validNext   = 1'b0;
                  end else begin
                     instrNext   = InstrF;
                     pcPlus4Next = pcPlus4F;
                     validNext   = 1'b1;
                  end
               end
            end
         end
         HALTED: begin
            instrNext   = NOP_INSTR;
            pcPlus4Next = '0;
            validNext   = 1'b0;
         end
         default: begin
            stateNext   = BOOT;
            instrNext   = NOP_INSTR;
            pcPlus4Next = '0;
            validNext   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BOOT;
         PCF      <= RESET_PC;
         InstrD   <= NOP_INSTR;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else begin
         state    <= stateNext;
         PCF      <= pcNext;
         InstrD   <= instrNext;
         PCPlus4D <= pcPlus4Next;
         ValidD   <= validNext;
      end
   end

endmodule
